// File: rtl/arm_pkg.sv
// Shared types and constants for the instruction fetch stage.
package arm_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_PC     = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;
   localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

   function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/pc_next.sv
// Next fetch PC and next memory request address, purely combinational.
module pc_next
   import arm_pkg::*;
(
   input  fetch_state_t state_q,
   input  logic [31:0]  pcf_q,
   input  logic [31:0]  req_addr_q,
   input  logic [31:0]  hold_pc_q,
   input  logic         branch_taken,
   input  logic [31:0]  branch_target,
   input  logic         imem_ready,
   input  logic         flush,
   output logic [31:0]  pcf_next,
   output logic [31:0]  req_addr_next
);

   logic [31:0] target_aligned;
   logic [31:0] pc_inc;

   assign target_aligned = branch_target & ~32'h3;
   assign pc_inc         = pc_add(pcf_q, PC_STEP);

   always_comb begin
      pcf_next      = pcf_q;
      req_addr_next = req_addr_q;
      if (branch_taken) begin
         pcf_next = target_aligned;
         // An outstanding request must keep its address until the memory answers.
         if (state_q == HOLD || imem_ready) begin
            req_addr_next = target_aligned;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ready && !flush) begin
                  pcf_next      = pc_inc;
                  req_addr_next = pc_inc;
               end
            end
            HOLD: begin
               if (flush) begin
                  pcf_next      = hold_pc_q;
                  req_addr_next = hold_pc_q;
               end else begin
                  req_addr_next = pcf_q;
               end
            end
            DISCARD: begin
               if (imem_ready) begin
                  req_addr_next = pcf_q;
               end
            end
            default: begin
               pcf_next      = pcf_q;
               req_addr_next = req_addr_q;
            end
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request FSM, one-entry hold buffer and the decode register.
module fetch_unit
   import arm_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemReady,
   input  logic [31:0] ImemRdata,
   input  logic        BranchTakenE,
   input  logic [31:0] BranchTargetE,
   input  logic        StallD,
   input  logic        FlushD,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus8D,
   output logic        ValidD
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pcf_q, pcf_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  dec_instr_q, dec_instr_d;
   logic [31:0]  dec_pc8_q, dec_pc8_d;
   logic         dec_valid_q, dec_valid_d;
   logic [31:0]  hold_instr_q, hold_instr_d;
   logic [31:0]  hold_pc_q, hold_pc_d;

   pc_next u_pc_next (
      .state_q       (state_q),
      .pcf_q         (pcf_q),
      .req_addr_q    (req_addr_q),
      .hold_pc_q     (hold_pc_q),
      .branch_taken  (BranchTakenE),
      .branch_target (BranchTargetE),
      .imem_ready    (ImemReady),
      .flush         (FlushD),
      .pcf_next      (pcf_d),
      .req_addr_next (req_addr_d)
   );

   always_comb begin
      state_d      = state_q;
      dec_instr_d  = dec_instr_q;
      dec_pc8_d    = dec_pc8_q;
      dec_valid_d  = dec_valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      if (BranchTakenE) begin
         dec_valid_d = 1'b0;
         if (state_q == HOLD || ImemReady) begin
            state_d = FETCH;
         end else begin
            state_d = DISCARD;
         end
      end else begin
         if (FlushD) begin
            dec_valid_d = 1'b0;
            dec_instr_d = BUBBLE_INSTR;
         end
         case (state_q)
            FETCH: begin
               if (ImemReady && !FlushD) begin
                  if (StallD) begin
                     hold_instr_d = ImemRdata;
                     hold_pc_d    = pcf_q;
                     state_d      = HOLD;
                  end else begin
                     dec_instr_d = ImemRdata;
                     dec_pc8_d   = pc_add(pcf_q, 32'd8);
                     dec_valid_d = 1'b1;
                  end
               end else if (!ImemReady && !StallD && !FlushD) begin
                  dec_valid_d = 1'b0;
               end
            end
            HOLD: begin
               // A flush drops the buffered word too; pc_next rewinds to refetch it.
               if (FlushD) begin
                  state_d = FETCH;
               end else if (!StallD) begin
                  dec_instr_d = hold_instr_q;
                  dec_pc8_d   = pc_add(hold_pc_q, 32'd8);
                  dec_valid_d = 1'b1;
                  state_d     = FETCH;
               end
            end
            DISCARD: begin
               if (!StallD && !FlushD) begin
                  dec_valid_d = 1'b0;
               end
               if (ImemReady) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FETCH;
         pcf_q        <= RESET_PC;
         req_addr_q   <= RESET_PC;
         dec_instr_q  <= BUBBLE_INSTR;
         dec_pc8_q    <= 32'h0;
         dec_valid_q  <= 1'b0;
         hold_instr_q <= BUBBLE_INSTR;
         hold_pc_q    <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pcf_q        <= pcf_d;
         req_addr_q   <= req_addr_d;
         dec_instr_q  <= dec_instr_d;
         dec_pc8_q    <= dec_pc8_d;
         dec_valid_q  <= dec_valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   // Gated by reset so no request is visible while reset is held.
   assign ImemReq  = reset && (state_q != HOLD);
   assign ImemAddr = req_addr_q;
   assign PCF      = pcf_q;
   assign InstrD   = dec_instr_q;
   assign PCPlus8D = dec_pc8_q;
   assign ValidD   = dec_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: expected decode stream queued by the driver, checked by a monitor.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemReady;
   logic [31:0] ImemRdata;
   logic        BranchTakenE;
   logic [31:0] BranchTargetE;
   logic        StallD;
   logic        FlushD;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCPlus8D;
   logic        ValidD;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .ImemReq       (ImemReq),
      .ImemAddr      (ImemAddr),
      .ImemReady     (ImemReady),
      .ImemRdata     (ImemRdata),
      .BranchTakenE  (BranchTakenE),
      .BranchTargetE (BranchTargetE),
      .StallD        (StallD),
      .FlushD        (FlushD),
      .PCF           (PCF),
      .InstrD        (InstrD),
      .PCPlus8D      (PCPlus8D),
      .ValidD        (ValidD)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc8;
   } exp_t;

   int          vectors     = 0;
   int          miscompares = 0;
   int          pops        = 0;
   exp_t        exp_q[$];
   logic [31:0] next_push_pc = 32'h0;

   // Program image: every address holds a distinct, non-zero word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Architectural view: instructions reach decode in program order from the last redirect.
   task automatic topup();
      exp_t e;
      while (exp_q.size() < 16) begin
         e.instr = mem_word(next_push_pc);
         e.pc8   = next_push_pc + 32'd8;
         exp_q.push_back(e);
         next_push_pc = next_push_pc + 32'd4;
      end
   endtask

   task automatic restart_stream(input logic [31:0] pc);
      exp_q.delete();
      next_push_pc = pc;
      topup();
   endtask

   task automatic step(input bit rdy, input bit stl, input bit fl, input bit br, input logic [31:0] tgt);
      ImemReady     = rdy && ImemReq;
      ImemRdata     = ImemReady ? mem_word(ImemAddr) : $urandom;
      StallD        = stl;
      FlushD        = fl;
      BranchTakenE  = br;
      BranchTargetE = tgt;
      if (br) restart_stream(tgt & ~32'h3);
      else topup();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every valid instruction leaving decode (accepted or flushed).
   initial begin : monitor
      bit          prev_kill;
      bit          prev_flush;
      bit          prev_wait;
      logic [31:0] prev_addr;
      exp_t        e;
      prev_kill  = 1'b0;
      prev_flush = 1'b0;
      prev_wait  = 1'b0;
      prev_addr  = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_kill  = 1'b0;
            prev_flush = 1'b0;
            prev_wait  = 1'b0;
         end else begin
            if (prev_kill)  check("valid_after_kill", {31'h0, ValidD}, 32'h0);
            if (prev_flush) check("instr_after_flush", InstrD, 32'h0);
            if (prev_wait)  check("addr_stable", ImemAddr, prev_addr);
            check("addr_align", {30'h0, ImemAddr[1:0]}, 32'h0);
            if (ValidD && !BranchTakenE && (!StallD || FlushD)) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL stream_empty: got instr %h, expected none (t=%0t)", InstrD, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("stream_instr", InstrD, e.instr);
                  check("stream_pc8", PCPlus8D, e.pc8);
                  pops++;
               end
            end
            prev_kill  = BranchTakenE || FlushD;
            prev_flush = FlushD && !BranchTakenE;
            prev_wait  = ImemReq && !ImemReady;
            prev_addr  = ImemAddr;
         end
      end
   end

   initial begin : driver
      int last_pops;
      int idle;
      bit rdy, stl, fl, br;
      logic [31:0] tgt;

      reset = 1'b0;
      ImemReady = 1'b1;
      ImemRdata = 32'h1234_5678;
      BranchTakenE = 1'b0;
      BranchTargetE = 32'h0;
      StallD = 1'b0;
      FlushD = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", {31'h0, ImemReq}, 32'h0);
      check("rst_pcf", PCF, 32'h0);
      check("rst_instr", InstrD, 32'h0);
      check("rst_pc8", PCPlus8D, 32'h0);
      check("rst_valid", {31'h0, ValidD}, 32'h0);

      reset = 1'b1;
      restart_stream(32'h0);
      #1;
      check("post_rst_req", {31'h0, ImemReq}, 32'h1);
      check("post_rst_addr", ImemAddr, 32'h0);

      // Zero-wait sequential fetch.
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 32'h0);
         check("seq_instr", InstrD, mem_word(32'(4 * i)));
         check("seq_pc8", PCPlus8D, 32'(4 * i + 8));
      end
      // Three wait cycles at 0xC.
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 32'h0);
         check("wait_valid", {31'h0, ValidD}, 32'h0);
         check("wait_addr", ImemAddr, 32'hC);
      end
      step(1, 0, 0, 0, 32'h0);
      check("wait_instr", InstrD, mem_word(32'hC));

      // Stall while word@0x10 returns.
      step(1, 1, 0, 0, 32'h0);
      check("hold_req", {31'h0, ImemReq}, 32'h0);
      check("hold_instr", InstrD, mem_word(32'hC));
      step(0, 1, 0, 0, 32'h0);
      check("hold_instr2", InstrD, mem_word(32'hC));
      step(0, 0, 0, 0, 32'h0);
      check("release_instr", InstrD, mem_word(32'h10));
      check("release_addr", ImemAddr, 32'h14);
      check("release_req", {31'h0, ImemReq}, 32'h1);

      // Redirect to 0x100 (low bits ignored) while 0x14 is pending.
      step(0, 0, 0, 1, 32'h103);
      check("disc_addr", ImemAddr, 32'h14);
      check("disc_pcf", PCF, 32'h100);
      check("disc_valid", {31'h0, ValidD}, 32'h0);
      step(0, 0, 0, 0, 32'h0);
      check("disc_addr2", ImemAddr, 32'h14);
      step(1, 0, 0, 0, 32'h0);
      check("disc_next_addr", ImemAddr, 32'h100);
      check("disc_valid2", {31'h0, ValidD}, 32'h0);
      step(1, 0, 0, 0, 32'h0);
      check("tgt_instr", InstrD, mem_word(32'h100));
      check("tgt_pc8", PCPlus8D, 32'h108);

      // Flush and stall together with a returning word: refetch.
      step(1, 1, 1, 0, 32'h0);
      check("flush_valid", {31'h0, ValidD}, 32'h0);
      check("flush_instr", InstrD, 32'h0);
      check("flush_pcf", PCF, 32'h104);
      check("flush_addr", ImemAddr, 32'h104);

      // Randomized phase, including redirects near the top of the address space.
      last_pops = pops;
      idle = 0;
      for (int i = 0; i < 2500; i++) begin
         rdy = ($urandom_range(0, 99) < 70);
         stl = ($urandom_range(0, 99) < 25);
         fl  = ($urandom_range(0, 99) < 5);
         br  = ($urandom_range(0, 99) < 4);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                           : 32'($urandom_range(0, 1023));
         step(rdy, stl, fl, br, tgt);
         if (pops != last_pops) begin
            last_pops = pops;
            idle = 0;
         end else begin
            idle++;
         end
         if (idle > 300) begin
            vectors++;
            miscompares++;
            $display("FAIL progress: got %0d idle cycles, expected at most 300", idle);
            break;
         end
      end
      vectors++;
      if (pops < 200) begin
         miscompares++;
         $display("FAIL throughput: got %0d instructions, expected at least 200", pops);
      end

      // Reset asserted while holding a stalled word.
      for (int i = 0; i < 5 && ImemReq; i++) step(1, 1, 0, 0, 32'h0);
      check("pre_rst_hold_req", {31'h0, ImemReq}, 32'h0);
      #2;
      reset = 1'b0;
      ImemReady = 1'b1;
      ImemRdata = 32'hFFFF_FFFF;
      #1;
      check("mid_rst_pcf", PCF, 32'h0);
      check("mid_rst_instr", InstrD, 32'h0);
      check("mid_rst_pc8", PCPlus8D, 32'h0);
      check("mid_rst_valid", {31'h0, ValidD}, 32'h0);
      check("mid_rst_req", {31'h0, ImemReq}, 32'h0);
      check("mid_rst_addr", ImemAddr, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      StallD = 1'b0;
      restart_stream(32'h0);
      #1;
      check("rerst_req", {31'h0, ImemReq}, 32'h1);
      check("rerst_addr", ImemAddr, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 32'h0);
         check("rerst_instr", InstrD, mem_word(32'(4 * i)));
      end
      step(0, 0, 0, 0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ImemReq  output  1  instruction-memory request.
REQ-004 SHALL have port: ImemAddr  output  32  request word address, bits [1:0]=0.
REQ-005 SHALL have port: ImemReady  input  1  response valid this cycle, completes the request.
REQ-006 SHALL have port: ImemRdata  input  32  instruction word, valid when ImemReady=1.
REQ-007 SHALL have port: BranchTakenE  input  1  redirect request from execute.
REQ-008 SHALL have port: BranchTargetE  input  32  redirect address; bits [1:0] ignored, forced 0.
REQ-009 SHALL have port: StallD  input  1  decode not accepting; decode register holds.
REQ-010 SHALL have port: FlushD  input  1  invalidate decode register.
REQ-011 SHALL have port: PCF  output  32  current fetch PC.
REQ-012 SHALL have port: InstrD  output  32  decode-stage instruction.
REQ-013 SHALL have port: PCPlus8D  output  32  PC of InstrD plus 8.
REQ-014 SHALL have port: ValidD  output  1  InstrD holds a real instruction.

Function
REQ-015 SHALL implement FSM states FETCH, HOLD, DISCARD.
REQ-016 FETCH SHALL drive ImemReq=1, ImemAddr=ReqAddr; ReqAddr SHALL stay stable until ImemReady=1.
REQ-017 FETCH, ImemReady=1, no redirect, no flush, StallD=0: next cycle InstrD=ImemRdata, PCPlus8D=PCF+8, ValidD=1, PCF=ReqAddr=PCF+4.
REQ-018 FETCH, ImemReady=1, StallD=1: word SHALL go to hold buffer (with its PC), PCF advances by 4, state->HOLD; decode register unchanged.
REQ-019 FETCH, ImemReady=0, StallD=0: ValidD SHALL become 0 (bubble); PCF unchanged.
REQ-020 HOLD SHALL drive ImemReq=0; when StallD=0, hold buffer SHALL load decode register (ValidD=1) next cycle, state->FETCH.
REQ-021 StallD=1 SHALL hold InstrD, PCPlus8D and ValidD unchanged in every state unless FlushD=1.
REQ-022 BranchTakenE=1 SHALL have top priority: next PCF=BranchTargetE, ValidD=0, hold buffer dropped.
REQ-023 Redirect in FETCH with ImemReady=0: state->DISCARD, ImemAddr held at the stale ReqAddr, ImemReq=1.
REQ-024 DISCARD: on ImemReady=1 the word SHALL be dropped, ReqAddr=PCF, state->FETCH; further redirects only update PCF.
REQ-025 Redirect in FETCH with ImemReady=1 same cycle: word dropped, ReqAddr=PCF=target, stay FETCH.
REQ-026 FlushD=1 (no redirect) SHALL clear ValidD and set InstrD=0 next cycle; a word returned that cycle is dropped and PCF not advanced (refetch).
REQ-027 FlushD SHALL take priority over StallD.
REQ-028 PC increment SHALL wrap modulo 2^32 (0xFFFFFFFC+4=0x00000000).

Reset
REQ-029 reset=0 SHALL asynchronously set PCF=ReqAddr=0, InstrD=0, PCPlus8D=0, ValidD=0, state=FETCH, hold buffer invalid.
REQ-030 ImemReq SHALL be 0 while reset=0 and 1 in the first cycle after release, ImemAddr=0.
REQ-031 Reset mid-request SHALL abandon the outstanding request; any ImemReady during reset SHALL be ignored.

Structure
REQ-032 Shared package arm_pkg SHALL hold fetch_state_t enum, RESET_PC=32'h0, PC_STEP=4, BUBBLE_INSTR=32'h0.
REQ-033 One sub-module SHALL be natural: pc_next (combinational next-PC/ReqAddr select); FSM and registers stay in fetch_unit.

Verification
REQ-034 Zero-wait memory, no stalls: after reset InstrD follows words at 0,4,8 on consecutive cycles, PCPlus8D=8,0xC,0x10.
REQ-035 ImemReady low 3 cycles at addr 4: ImemAddr stays 4, ValidD=0 for 3 cycles, then InstrD=word@4.
REQ-036 StallD=1 two cycles while word@8 returns: InstrD holds word@4, state HOLD, ImemReq=0; on release InstrD=word@8, then fetch 0xC.
REQ-037 BranchTakenE, target 0x100, while addr 0x10 pending: ImemAddr held 0x10 until ImemReady, word dropped, next request 0x100, ValidD=0 throughout.
REQ-038 FlushD and StallD together with ImemReady=1 at 0x20: ValidD=0, InstrD=0, PCF stays 0x20, 0x20 refetched.
REQ-039 Reset asserted mid-HOLD: all outputs at reset values immediately; after release first request at 0x0.
